ps2_key_event_parser: RTL and testbench
=======================================

Name: ps2_key_event_parser

Overview:
- Consumes the raw scancode byte queue from the PS/2 decoder stage and turns Set-2 make/break/extended sequences into single key events.
- Also maintains an 8-bit held-note bitmap (home-row keys A..K) that the organ tone stage reads directly.
- Sits between the PS/2 decoder's byte FIFO and the organ's note/tone logic.

Parameters:
- TIMEOUT_CYC, 2000000, sys_clk cycles a pending prefix (E0/F0/E1-skip) may wait for its next byte before being abandoned (20 ms @ 100 MHz).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- code_data  in  8  scancode byte at the head of the upstream queue (combinational from upstream)
- code_valid  in  1  upstream queue non-empty
- code_rd  out  1  pop strobe to upstream; a byte is consumed on a cycle with code_valid && code_rd
- evt_valid  out  1  key event available
- evt_ready  in  1  downstream accepts the event on evt_valid && evt_ready
- evt_code  out  8  key scancode (prefixes stripped)
- evt_ext  out  1  key was E0-prefixed
- evt_break  out  1  1 = release, 0 = press
- note_held  out  8  bit n set while note key n is held
- proto_err  out  1  sticky, set on an illegal sequence

Behaviour:
- Reset: state IDLE, timeout counter 0, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, note_held=0, proto_err=0, code_rd=0. Reset mid-sequence discards the partial sequence and any pending event; upstream bytes are not flushed.
- code_rd = code_valid && !(evt_valid && !evt_ready). It is combinational, so the parser pops at most one byte per cycle. It never pops while holding an unaccepted event.
- Event register: on the cycle a terminating byte is consumed, evt_* load in the next cycle and evt_valid goes to 1. The register holds until evt_valid && evt_ready. If a new terminating byte is consumed in the same cycle as acceptance, evt_valid stays 1 with the new contents.
- States and transitions on a consumed byte b:
  - IDLE:
    - b=E0 -> GOT_E0.
    - b=F0 -> GOT_F0.
    - b=E1 -> SKIP with skip count 7 (pause sequence, no event).
    - b in {00,AA,EE,FA,FC,FD,FE,FF} -> dropped, stay IDLE.
    - Any other b -> make event (ext=0, code=b), stay IDLE.
  - GOT_E0:
    - b=F0 -> GOT_E0F0.
    - b=E0 or E1 -> proto_err=1, -> IDLE.
    - Any other b -> make event (ext=1, code=b), -> IDLE.
  - GOT_F0:
    - b in {E0,E1,F0} -> proto_err=1, -> IDLE.
    - Any other b -> break event (ext=0), -> IDLE.
  - GOT_E0F0:
    - b in {E0,E1,F0} -> proto_err=1, -> IDLE.
    - Any other b -> break event (ext=1), -> IDLE.
  - SKIP: decrement the skip count per consumed byte; after the 7th byte -> IDLE.
- Timeout: in any non-IDLE state, the counter increments each cycle with no consumed byte and clears on each consumed byte. At TIMEOUT_CYC the state returns to IDLE without setting proto_err. The counter is held at 0 in IDLE. Width is $clog2(TIMEOUT_CYC+1).
- Note map (ext=0 only): 1C->0, 1B->1, 23->2, 2B->3, 34->4, 33->5, 3B->6, 42->7.
  - A make sets the bit and a break clears it. The update occurs in the same cycle evt_* loads.
  - The update is independent of evt_ready and of the optional filter.
  - E0-prefixed codes never touch note_held.
- proto_err clears only on rst.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Add a 512-entry held table indexed {ext, code}. A make sets the entry and a break clears it.
  - A make for an entry already set is consumed but produces no event.
  - Breaks are always forwarded. The table clears on rst.
- Undefined: no table; every make, including typematic repeats, produces an event.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> event {1C, ext0, brk0}, then {1C, ext0, brk1}; note_held=01 after the first event and 00 after the second; proto_err=0.
- Bytes E0, 75, E0, F0, 75 -> events {75, ext1, brk0} and {75, ext1, brk1}; note_held stays 00.
- Bytes 1C, 1B with evt_ready held low -> one event {1C} pending, code_rd=0 with code_valid=1. Raise evt_ready -> 1B consumed and event {1B} appears; note_held=03.
- Bytes E1, 14, 77, E1, F0, 14, F0, 77, then 42 -> no event for the first 8 bytes; event {42, brk0}; note_held bit7 set.
- Byte F0, then no bytes for TIMEOUT_CYC cycles, then 23 -> state returns to IDLE; event is a make {23, brk0}, not a break; proto_err=0. Separately, F0, F0 -> proto_err=1 and no event.
- With PS2_TYPEMATIC_FILTER_EN: bytes 34, 34, 34, F0, 34 -> exactly 2 events (make, break). Without the macro -> 4 events.

Source files
------------

// File: rtl/ps2_key_event_parser.sv
// PS/2 Set-2 scancode parser: make/break/extended bytes in, key events and held-note bitmap out.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeat makes.
module ps2_key_event_parser #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] code_data,
  input  logic       code_valid,
  output logic       code_rd,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] note_held,
  output logic       proto_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          perr_q, perr_d;
  logic [7:0]    note_q, note_d;
  logic          evt_valid_q, evt_valid_d;
  logic [7:0]    evt_code_q, evt_code_d;
  logic          evt_ext_q, evt_ext_d;
  logic          evt_break_q, evt_break_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]  held_q, held_d;
`endif

  logic          fire;
  logic          f_ext;
  logic          f_brk;
  logic          suppress;
  logic [3:0]    ni;

  function automatic logic [3:0] note_idx(input logic [7:0] c);
    logic [3:0] r;
    r = 4'h0;
    unique case (c)
      8'h1C:   r = 4'b1000;
      8'h1B:   r = 4'b1001;
      8'h23:   r = 4'b1010;
      8'h2B:   r = 4'b1011;
      8'h34:   r = 4'b1100;
      8'h33:   r = 4'b1101;
      8'h3B:   r = 4'b1110;
      8'h42:   r = 4'b1111;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic is_drop(input logic [7:0] c);
    logic r;
    r = 1'b0;
    unique case (c)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_pfx(input logic [7:0] c);
    return (c == 8'hE0) || (c == 8'hE1) || (c == 8'hF0);
  endfunction

  // Never pop a byte while an unaccepted event would be overwritten.
  assign code_rd = code_valid && !(evt_valid_q && !evt_ready);

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    perr_d      = perr_q;
    note_d      = note_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_break_d = evt_break_q;
    fire        = 1'b0;
    f_ext       = 1'b0;
    f_brk       = 1'b0;
    suppress    = 1'b0;
    ni          = 4'h0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    held_d      = held_q;
`endif

    if (code_rd) begin
      unique case (state_q)
        S_IDLE: begin
          if (code_data == 8'hE0) begin
            state_d = S_E0;
          end else if (code_data == 8'hF0) begin
            state_d = S_F0;
          end else if (code_data == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_drop(code_data)) begin
            fire = 1'b1;
          end
        end
        S_E0: begin
          state_d = S_IDLE;
          if (code_data == 8'hF0) begin
            state_d = S_E0F0;
          end else if (code_data == 8'hE0 || code_data == 8'hE1) begin
            perr_d = 1'b1;
          end else begin
            fire  = 1'b1;
            f_ext = 1'b1;
          end
        end
        S_F0: begin
          state_d = S_IDLE;
          if (is_pfx(code_data)) begin
            perr_d = 1'b1;
          end else begin
            fire  = 1'b1;
            f_brk = 1'b1;
          end
        end
        S_E0F0: begin
          state_d = S_IDLE;
          if (is_pfx(code_data)) begin
            perr_d = 1'b1;
          end else begin
            fire  = 1'b1;
            f_ext = 1'b1;
            f_brk = 1'b1;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Abandon a stalled prefix silently; the counter only runs mid-sequence.
    if (state_q == S_IDLE || code_rd) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    if (fire) begin
      suppress = !f_brk && held_q[{f_ext, code_data}];
      held_d[{f_ext, code_data}] = !f_brk;
    end
`endif

    ni = note_idx(code_data);
    if (fire && !f_ext && ni[3]) note_d[ni[2:0]] = !f_brk;

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (fire && !suppress) begin
      evt_valid_d = 1'b1;
      evt_code_d  = code_data;
      evt_ext_d   = f_ext;
      evt_break_d = f_brk;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      cnt_q       <= '0;
      perr_q      <= 1'b0;
      note_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_break_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      perr_q      <= perr_d;
      note_q      <= note_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_break_q <= evt_break_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q      <= held_d;
`endif
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ext   = evt_ext_q;
  assign evt_break = evt_break_q;
  assign note_held = note_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_ps2_key_event_parser.sv
// Scoreboard bench for ps2_key_event_parser: byte feeder, expected-event queue, accept monitor.
module tb_ps2_key_event_parser;

  localparam int TO = 50;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_data = 8'h00;
  logic       code_valid = 1'b0;
  logic       code_rd;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] note_held;
  logic       proto_err;

  int total = 0;
  int bad = 0;
  int n_evt = 0;

  logic [7:0] byteq[$];
  logic [9:0] expq[$];

  ps2_key_event_parser #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .code_data (code_data),
    .code_valid(code_valid),
    .code_rd   (code_rd),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .note_held (note_held),
    .proto_err (proto_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk)
    if (code_valid && code_rd && byteq.size() != 0)
      void'(byteq.pop_front());

  always @(negedge sys_clk) begin
    code_valid = byteq.size() != 0;
    code_data  = (byteq.size() != 0) ? byteq[0] : 8'h00;
  end

  always @(negedge sys_clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_evt++;
      if (expq.size() == 0) begin
        chk("evt_extra", {22'h0, evt_code, evt_ext, evt_break}, 32'hFFFF);
      end else begin
        chk("evt", {22'h0, evt_code, evt_ext, evt_break},
            {22'h0, expq.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    byteq.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic e,
                            input logic k);
    expq.push_back({c, e, k});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((byteq.size() != 0 || expq.size() != 0) && n < 2000) begin
      @(posedge sys_clk);
      n++;
    end
    tick(4);
    chk("drain_budget", n >= 2000, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  int base;

  initial begin
    do_reset();
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", {evt_code, evt_ext, evt_break}, 0);
    chk("rst_note", note_held, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_code_rd", code_rd, 0);

    send(8'h1C); expect_evt(8'h1C, 0, 0);
    drain();
    chk("note_after_make", note_held, 8'h01);
    send(8'hF0); send(8'h1C); expect_evt(8'h1C, 0, 1);
    drain();
    chk("note_after_break", note_held, 8'h00);
    chk("perr_t1", proto_err, 0);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt(8'h75, 1, 0); expect_evt(8'h75, 1, 1);
    drain();
    chk("note_ext", note_held, 8'h00);

    base = n_evt;
    send(8'hAA); send(8'hFA); send(8'h00);
    drain();
    chk("dropped_cnt", n_evt - base, 0);

    evt_ready = 1'b0;
    send(8'h1C); send(8'h1B);
    expect_evt(8'h1C, 0, 0); expect_evt(8'h1B, 0, 0);
    tick(10);
    chk("stall_valid", evt_valid, 1);
    chk("stall_code", evt_code, 8'h1C);
    chk("stall_code_valid", code_valid, 1);
    chk("stall_code_rd", code_rd, 0);
    evt_ready = 1'b1;
    drain();
    chk("note_stall", note_held, 8'h03);

    base = n_evt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h42); expect_evt(8'h42, 0, 0);
    drain();
    chk("pause_cnt", n_evt - base, 1);
    chk("note_pause", note_held, 8'h83);

    send(8'hF0);
    tick(TO + 10);
    send(8'h23); expect_evt(8'h23, 0, 0);
    drain();
    chk("note_timeout", note_held, 8'h87);
    chk("perr_timeout", proto_err, 0);

    base = n_evt;
    send(8'hF0); send(8'hF0);
    drain();
    chk("perr_f0f0", proto_err, 1);
    chk("f0f0_cnt", n_evt - base, 0);

    do_reset();
    chk("rst2_note", note_held, 0);
    chk("rst2_perr", proto_err, 0);
    base = n_evt;
    send(8'h34); send(8'h34); send(8'h34); send(8'hF0); send(8'h34);
    expect_evt(8'h34, 0, 0);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expect_evt(8'h34, 0, 0);
    expect_evt(8'h34, 0, 0);
`endif
    expect_evt(8'h34, 0, 1);
    drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_cnt", n_evt - base, 2);
`else
    chk("typematic_cnt", n_evt - base, 4);
`endif
    chk("note_typematic", note_held, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
